// File: rtl/second_countdown.sv
// Programmable seconds countdown driven by the 1 Hz second_tick; loads a duration,
// counts it down, pulses expired on reaching zero, with pause, abort and optional auto-reload.
module second_countdown #(
    parameter int CNT_W       = 16,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             start,
    input  logic [CNT_W-1:0] duration,
    input  logic             pause,
    input  logic             abort,
    input  logic             second_tick,
    output logic             timer_enable,
    output logic             start_ack,
    output logic             busy,
    output logic             paused,
    output logic [CNT_W-1:0] remaining,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] reload_reg;
    logic             start_ack_q;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state       <= IDLE;
            remaining_q <= '0;
            reload_reg  <= '0;
            start_ack_q <= 1'b0;
        end else begin
            start_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    // abort takes precedence over a simultaneous start
                    if (start && !abort) begin
                        reload_reg  <= duration;
                        remaining_q <= duration;
                        start_ack_q <= 1'b1;
                        state       <= (duration == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        remaining_q <= '0;
                        state       <= IDLE;
                    end else if (second_tick && remaining_q <= CNT_W'(1)) begin
                        // final tick beats a coincident pause
                        remaining_q <= '0;
                        state       <= DONE;
                    end else begin
                        if (second_tick)
                            remaining_q <= remaining_q - 1'b1;
                        if (pause)
                            state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        remaining_q <= '0;
                        state       <= IDLE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    // a zero reload returns to IDLE rather than pulsing every other cycle
                    if (!abort && AUTO_RELOAD && reload_reg != '0) begin
                        remaining_q <= reload_reg;
                        state       <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign timer_enable = (state == RUN);
    assign busy         = (state != IDLE);
    assign paused       = (state == PAUSE);
    assign expired      = (state == DONE);
    assign start_ack    = start_ack_q;
    assign remaining    = remaining_q;

endmodule

// File: tb/tb_second_countdown.sv
// Randomized and directed bench for second_countdown; one instance per AUTO_RELOAD
// setting, each compared every cycle against a behavioural model.
module tb_second_countdown;

    logic        clk = 1'b0;
    logic        async_nreset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] duration = '0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic        second_tick = 1'b0;

    logic        te   [2];
    logic        ack  [2];
    logic        bsy  [2];
    logic        pau  [2];
    logic [15:0] rem  [2];
    logic        expd [2];

    int n_checks = 0;
    int n_fail   = 0;
    int exp1_cnt = 0;

    // model: counting = RUN, held = PAUSE, fire = expiry cycle
    bit        m_counting [2];
    bit        m_held     [2];
    bit        m_fire     [2];
    bit        m_ack      [2];
    int        m_rem      [2];
    int        m_reload   [2];

    always #10 clk = ~clk;

    second_countdown #(.CNT_W(16), .AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .async_nreset(async_nreset), .start(start), .duration(duration),
        .pause(pause), .abort(abort), .second_tick(second_tick),
        .timer_enable(te[0]), .start_ack(ack[0]), .busy(bsy[0]), .paused(pau[0]),
        .remaining(rem[0]), .expired(expd[0])
    );

    second_countdown #(.CNT_W(16), .AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .async_nreset(async_nreset), .start(start), .duration(duration),
        .pause(pause), .abort(abort), .second_tick(second_tick),
        .timer_enable(te[1]), .start_ack(ack[1]), .busy(bsy[1]), .paused(pau[1]),
        .remaining(rem[1]), .expired(expd[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_counting[k] = 0; m_held[k] = 0; m_fire[k] = 0; m_ack[k] = 0;
            m_rem[k] = 0; m_reload[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit ar);
        m_ack[k] = 0;
        if (m_fire[k]) begin
            m_fire[k] = 0;
            if (!abort && ar && m_reload[k] != 0) begin
                m_rem[k] = m_reload[k];
                m_counting[k] = 1;
            end
        end else if (m_held[k]) begin
            if (abort) begin
                m_held[k] = 0; m_rem[k] = 0;
            end else if (!pause) begin
                m_held[k] = 0; m_counting[k] = 1;
            end
        end else if (m_counting[k]) begin
            if (abort) begin
                m_counting[k] = 0; m_rem[k] = 0;
            end else if (second_tick && m_rem[k] <= 1) begin
                m_counting[k] = 0; m_rem[k] = 0; m_fire[k] = 1;
            end else begin
                if (second_tick) m_rem[k] = m_rem[k] - 1;
                if (pause) begin
                    m_counting[k] = 0; m_held[k] = 1;
                end
            end
        end else if (start && !abort) begin
            m_reload[k] = int'(duration);
            m_rem[k] = int'(duration);
            m_ack[k] = 1;
            if (duration == 0) m_fire[k] = 1;
            else m_counting[k] = 1;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("timer_enable%0d", k), 32'(te[k]),   32'(m_counting[k]));
            check($sformatf("start_ack%0d", k),    32'(ack[k]),  32'(m_ack[k]));
            check($sformatf("busy%0d", k),         32'(bsy[k]),
                  32'(m_counting[k] | m_held[k] | m_fire[k]));
            check($sformatf("paused%0d", k),       32'(pau[k]),  32'(m_held[k]));
            check($sformatf("remaining%0d", k),    32'(rem[k]),  32'(m_rem[k]));
            check($sformatf("expired%0d", k),      32'(expd[k]), 32'(m_fire[k]));
        end
        if (expd[1] === 1'b1) exp1_cnt++;
    endtask

    task automatic step(input bit s, input int d, input bit p, input bit a, input bit t);
        @(negedge clk);
        compare_all();
        start = s; duration = 16'(d); pause = p; abort = a; second_tick = t;
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
    endtask

    task automatic idle_cycles(input int n, input int tick_every, input bit p);
        for (int i = 0; i < n; i++)
            step(0, 0, p, 0, (tick_every > 0) && ((i % tick_every) == tick_every - 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 async_nreset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_te",   32'(te[k]),   0);
            check("rst_ack",  32'(ack[k]),  0);
            check("rst_busy", 32'(bsy[k]),  0);
            check("rst_paus", 32'(pau[k]),  0);
            check("rst_rem",  32'(rem[k]),  0);
            check("rst_exp",  32'(expd[k]), 0);
        end
        model_reset();
        start = 0; pause = 0; abort = 0; second_tick = 0;
        @(negedge clk);
        async_nreset = 1'b1;
    endtask

    initial begin
        bit p_lvl;
        model_reset();
        do_reset();

        // 1: duration 3, ticks every 10 cycles
        step(1, 3, 0, 0, 0);
        #1 check("t1_ack", 32'(ack[0]), 1);
        idle_cycles(40, 10, 0);

        // 2: zero-length count
        step(1, 0, 0, 0, 0);
        #1 check("t2_te", 32'(te[0]), 0);
        step(0, 0, 0, 0, 1);
        #1 check("t2_exp", 32'(expd[0]), 0);
        idle_cycles(4, 0, 0);

        // 3: duration 5, pause after 2 ticks, ticks injected while paused
        step(1, 5, 0, 0, 0);
        idle_cycles(6, 3, 0);
        idle_cycles(30, 3, 1);
        #1 check("t3_rem", 32'(rem[0]), 3);
        idle_cycles(12, 4, 0);

        // 4: abort after one tick, start coincident with abort
        step(1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(1, 7, 0, 1, 0);
        #1 check("t4_busy", 32'(bsy[0]), 0);
        step(0, 0, 0, 0, 0);
        #1 check("t4_ack", 32'(ack[0]), 0);
        idle_cycles(3, 0, 0);

        // 5: auto-reload instance, duration 2, six ticks -> three expiries
        do_reset();
        exp1_cnt = 0;
        step(1, 2, 0, 0, 0);
        idle_cycles(30, 5, 0);
        step(0, 0, 0, 1, 0);
        idle_cycles(3, 0, 0);
        check("t5_expcnt", 32'(exp1_cnt), 3);

        // 6: pause with the final tick, then reset mid-run
        step(1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        #1 check("t6_paused", 32'(pau[0]), 0);
        check("t6_exp", 32'(expd[0]), 1);
        step(0, 0, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        idle_cycles(3, 0, 0);
        do_reset();

        // random phase
        p_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            bit s, a, t;
            int d;
            if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
            s = ($urandom_range(0, 5) == 0);
            a = !s && ($urandom_range(0, 39) == 0);
            t = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 5);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(s, d, p_lvl, a, t);
        end

        step(0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
